// File: rtl/rom_alu_pkg.sv
// Shared definitions for the ROM-driven ALU sequencer: opcodes, control-word
// layout, FSM states and the constant program / operand tables.
package rom_alu_pkg;

  // ALU opcodes; codes 8..15 are unassigned and produce zero.
  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_OR     = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_SLL    = 4'd5;
  localparam logic [3:0] OP_SRL    = 4'd6;
  localparam logic [3:0] OP_PASS_A = 4'd7;

  // Control-word layout: {last, acc_en, op[3:0], ia[3:0], ib[3:0]}.
  localparam int CW_W       = 14;
  localparam int CW_LAST    = 13;
  localparam int CW_ACC_EN  = 12;
  localparam int CW_OP_LSB  = 8;
  localparam int CW_IA_LSB  = 4;
  localparam int CW_IB_LSB  = 0;
  localparam int PROG_DEPTH = 16;
  localparam int OPTAB_DEPTH = 16;

  typedef struct packed {
    logic       last;
    logic       acc_en;
    logic [3:0] op;
    logic [3:0] ia;
    logic [3:0] ib;
  } ctrl_word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic ctrl_word_t mk_word(input logic last, input logic acc_en,
                                         input logic [3:0] op, input logic [3:0] ia,
                                         input logic [3:0] ib);
    ctrl_word_t w;
    w.last   = last;
    w.acc_en = acc_en;
    w.op     = op;
    w.ia     = ia;
    w.ib     = ib;
    return w;
  endfunction

  // Program ROM. no_last selects the step-limit variant in which every
  // last flag is cleared, so any run ends only through the step limit.
  function automatic ctrl_word_t prog_word(input logic [3:0] idx, input logic no_last);
    ctrl_word_t w;
    case (idx)
      4'd0:    w = mk_word(1'b1, 1'b0, OP_ADD, 4'd1, 4'd2);
      4'd1:    w = mk_word(1'b0, 1'b0, OP_ADD, 4'd2, 4'd2);
      4'd2:    w = mk_word(1'b0, 1'b1, OP_SUB, 4'd1, 4'd2);
      4'd3:    w = mk_word(1'b1, 1'b1, OP_SLL, 4'd2, 4'd1);
      4'd4:    w = mk_word(1'b1, 1'b0, OP_ADD, 4'd3, 4'd1);
      4'd5:    w = mk_word(1'b1, 1'b0, OP_SUB, 4'd0, 4'd2);
      default: w = mk_word(1'b0, 1'b0, OP_PASS_A, 4'd0, 4'd0);
    endcase
    if (no_last) begin
      w.last = 1'b0;
    end
    return w;
  endfunction

  // Operand table, 32 bits wide; resized to the datapath width by the user.
  function automatic logic [31:0] optab_word(input logic [3:0] idx);
    logic [31:0] v;
    case (idx)
      4'd0:    v = 32'h0000_0000;
      4'd1:    v = 32'h0000_0001;
      4'd2:    v = 32'h0000_0005;
      4'd3:    v = 32'hFFFF_FFFF;
      4'd4:    v = 32'h0000_0010;
      default: v = {20'h0_0000, idx, 8'h00};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rom_alu_core.sv
// Combinational ALU: one opcode applied to operands a and b.
// cout is the carry-out for ADD and the borrow for SUB, zero otherwise.
module rom_alu_core
  import rom_alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] y,
  output logic              cout
);

  // Opcode decode; unassigned opcodes fall through to zero.
  always_comb begin
    y    = '0;
    cout = 1'b0;
    case (op)
      OP_ADD:    {cout, y} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        y    = a - b;
        cout = (a < b);
      end
      OP_AND:    y = a & b;
      OP_OR:     y = a | b;
      OP_XOR:    y = a ^ b;
      OP_SLL:    y = a << b[4:0];
      OP_SRL:    y = a >> b[4:0];
      OP_PASS_A: y = a;
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/rom_alu_sequencer.sv
// Sequential ROM/ALU engine: walks the program ROM from a host-supplied
// address, accumulating ALU results, then hands the final value and flags
// to a downstream consumer over a valid/ready handshake.
module rom_alu_sequencer
  import rom_alu_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int PC_W         = 4,
  parameter int ABS_EN       = 1,
  // 0: normal program ROM; 1: same ROM with every last flag cleared.
  parameter int PROG_VARIANT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PC_W-1:0]   start_pc,
  output logic              ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              neg,
  output logic              err
);

  // Step count value at which a run without a last flag is forced to end.
  localparam logic [PC_W:0] STEP_LIMIT = {1'b1, {PC_W{1'b0}}};

  state_e            state_reg, state_next;
  logic [PC_W-1:0]   pc_reg, pc_next;
  logic [DATA_W-1:0] acc_reg, acc_next;
  logic [PC_W:0]     step_reg, step_next;
  logic              run_carry_reg, run_carry_next;
  logic              run_err_reg, run_err_next;
  logic              out_valid_reg, out_valid_next;
  logic [DATA_W-1:0] result_reg, result_next;
  logic              carry_reg, carry_next;
  logic              neg_reg, neg_next;
  logic              err_reg, err_next;

  ctrl_word_t        word;
  logic [DATA_W-1:0] op_a, op_b, alu_y, final_val;
  logic              alu_cout;

  // Control word and operands follow the registered pc combinationally.
  assign word = prog_word(4'(pc_reg), PROG_VARIANT != 0);
  assign op_a = DATA_W'(optab_word(word.ia));
  assign op_b = DATA_W'(optab_word(word.ib));

  rom_alu_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .a    (op_a),
    .b    (op_b),
    .op   (word.op),
    .y    (alu_y),
    .cout (alu_cout)
  );

  // Optional magnitude conversion; the most-negative value maps to itself.
  assign final_val = ((ABS_EN != 0) && acc_reg[DATA_W-1]) ? (~acc_reg + DATA_W'(1)) : acc_reg;

  assign ready     = (state_reg == ST_IDLE);
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign carry     = carry_reg;
  assign neg       = neg_reg;
  assign err       = err_reg;

  // Next-state and datapath updates for the IDLE -> EXEC -> DONE sequence.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    acc_next       = acc_reg;
    step_next      = step_reg;
    run_carry_next = run_carry_reg;
    run_err_next   = run_err_reg;
    out_valid_next = out_valid_reg;
    result_next    = result_reg;
    carry_next     = carry_reg;
    neg_next       = neg_reg;
    err_next       = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          pc_next        = start_pc;
          acc_next       = '0;
          step_next      = '0;
          run_carry_next = 1'b0;
          run_err_next   = 1'b0;
          state_next     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        acc_next       = word.acc_en ? (acc_reg + alu_y) : alu_y;
        run_carry_next = run_carry_reg | alu_cout;
        pc_next        = pc_reg + 1'b1;
        step_next      = step_reg + 1'b1;
        if (word.last) begin
          state_next = ST_DONE;
        end else if (step_next == STEP_LIMIT) begin
          run_err_next = 1'b1;
          state_next   = ST_DONE;
        end
      end
      ST_DONE: begin
        // First DONE cycle captures the outputs; later cycles wait for the consumer.
        if (!out_valid_reg) begin
          result_next    = final_val;
          neg_next       = acc_reg[DATA_W-1];
          carry_next     = run_carry_reg;
          err_next       = run_err_reg;
          out_valid_next = 1'b1;
        end else if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any run without output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      pc_reg        <= '0;
      acc_reg       <= '0;
      step_reg      <= '0;
      run_carry_reg <= 1'b0;
      run_err_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      carry_reg     <= 1'b0;
      neg_reg       <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      acc_reg       <= acc_next;
      step_reg      <= step_next;
      run_carry_reg <= run_carry_next;
      run_err_reg   <= run_err_next;
      out_valid_reg <= out_valid_next;
      result_reg    <= result_next;
      carry_reg     <= carry_next;
      neg_reg       <= neg_next;
      err_reg       <= err_next;
    end
  end

endmodule

// File: tb/tb_rom_alu_sequencer.sv
// Bench for rom_alu_sequencer: three instances (ABS on, ABS off, no-last
// program variant) driven from one initial block; expected results are
// queued at start time and compared when out_valid appears.
module tb_rom_alu_sequencer;

  typedef struct packed {
    logic [31:0] result;
    logic        carry;
    logic        neg;
    logic        err;
    logic [7:0]  lat;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_v     [3];
  logic [3:0]  start_pc_v  [3];
  logic        out_ready_v [3];
  logic        ready_v     [3];
  logic        out_valid_v [3];
  logic [31:0] result_v    [3];
  logic        carry_v     [3];
  logic        neg_v       [3];
  logic        err_v       [3];

  txn_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  rom_alu_sequencer #(.DATA_W(32), .PC_W(4), .ABS_EN(1), .PROG_VARIANT(0)) u_abs (
    .clk(clk), .rst(rst), .start(start_v[0]), .start_pc(start_pc_v[0]),
    .ready(ready_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .result(result_v[0]), .carry(carry_v[0]), .neg(neg_v[0]), .err(err_v[0]));

  rom_alu_sequencer #(.DATA_W(32), .PC_W(4), .ABS_EN(0), .PROG_VARIANT(0)) u_raw (
    .clk(clk), .rst(rst), .start(start_v[1]), .start_pc(start_pc_v[1]),
    .ready(ready_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .result(result_v[1]), .carry(carry_v[1]), .neg(neg_v[1]), .err(err_v[1]));

  rom_alu_sequencer #(.DATA_W(32), .PC_W(4), .ABS_EN(1), .PROG_VARIANT(1)) u_nolast (
    .clk(clk), .rst(rst), .start(start_v[2]), .start_pc(start_pc_v[2]),
    .ready(ready_v[2]), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .result(result_v[2]), .carry(carry_v[2]), .neg(neg_v[2]), .err(err_v[2]));

  // Push the expectation, then present start for exactly one rising edge.
  task automatic launch(input int u, input logic [3:0] pc, input txn_t e);
    exp_q.push_back(e);
    start_pc_v[u] = pc;
    start_v[u]    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[u]    = 1'b0;
  endtask

  // Wait (bounded) for out_valid, record outputs and cycles since accept,
  // then step one more edge so a held out_ready completes the handshake.
  task automatic collect(input int u, output txn_t obs);
    int n;
    n = 0;
    while (!out_valid_v[u] && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    obs = {result_v[u], carry_v[u], neg_v[u], err_v[u], 8'(n)};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      vectors++;
      if ({ready_v[u], out_valid_v[u], result_v[u], carry_v[u], neg_v[u], err_v[u]} !== {1'b1, 1'b0, 32'h0, 3'b000}) begin
        miscompares++;
        $display("FAIL reset_state u%0d: got ready=%b valid=%b result=%h c=%b n=%b e=%b, expected ready=1 valid=0 result=0 flags=0",
                 u, ready_v[u], out_valid_v[u], result_v[u], carry_v[u], neg_v[u], err_v[u]);
      end else begin
        $display("txn reset u%0d ok", u);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_programs();
    int          u_t  [10];
    logic [3:0]  pc_t [10];
    txn_t        e_t  [10];
    txn_t        obs, e;
    u_t[0] = 0; pc_t[0] = 4'd0; e_t[0] = {32'h0000_0006, 1'b0, 1'b0, 1'b0, 8'd2};
    u_t[1] = 0; pc_t[1] = 4'd1; e_t[1] = {32'h0000_0010, 1'b1, 1'b0, 1'b0, 8'd4};
    u_t[2] = 0; pc_t[2] = 4'd4; e_t[2] = {32'h0000_0000, 1'b1, 1'b0, 1'b0, 8'd2};
    u_t[3] = 0; pc_t[3] = 4'd5; e_t[3] = {32'h0000_0005, 1'b1, 1'b1, 1'b0, 8'd2};
    u_t[4] = 1; pc_t[4] = 4'd5; e_t[4] = {32'hFFFF_FFFB, 1'b1, 1'b1, 1'b0, 8'd2};
    u_t[5] = 1; pc_t[5] = 4'd1; e_t[5] = {32'h0000_0010, 1'b1, 1'b0, 1'b0, 8'd4};
    u_t[6] = 0; pc_t[6] = 4'd6; e_t[6] = {32'h0000_0006, 1'b0, 1'b0, 1'b0, 8'd12};
    u_t[7] = 2; pc_t[7] = 4'd6; e_t[7] = {32'h0000_0005, 1'b1, 1'b1, 1'b1, 8'd17};
    u_t[8] = 2; pc_t[8] = 4'd0; e_t[8] = {32'h0000_0000, 1'b1, 1'b0, 1'b1, 8'd17};
    u_t[9] = 2; pc_t[9] = 4'd4; e_t[9] = {32'h0000_0010, 1'b1, 1'b0, 1'b1, 8'd17};
    for (int i = 0; i < 10; i++) begin
      launch(u_t[i], pc_t[i], e_t[i]);
      collect(u_t[i], obs);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL program u%0d pc=%0d: got result=%h c=%b n=%b e=%b lat=%0d, expected result=%h c=%b n=%b e=%b lat=%0d",
                 u_t[i], pc_t[i], obs.result, obs.carry, obs.neg, obs.err, obs.lat,
                 e.result, e.carry, e.neg, e.err, e.lat);
      end else begin
        $display("txn program u%0d pc=%0d result=%h c=%b n=%b e=%b lat=%0d",
                 u_t[i], pc_t[i], obs.result, obs.carry, obs.neg, obs.err, obs.lat);
      end
    end
  endtask

  task automatic test_backpressure();
    txn_t obs, e;
    out_ready_v[0] = 1'b0;
    launch(0, 4'd1, {32'h0000_0010, 1'b1, 1'b0, 1'b0, 8'd4});
    collect(0, obs);
    e = exp_q.pop_front();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL stall_result: got result=%h c=%b lat=%0d, expected result=%h c=%b lat=%0d",
               obs.result, obs.carry, obs.lat, e.result, e.carry, e.lat);
    end else begin
      $display("txn stall result=%h lat=%0d", obs.result, obs.lat);
    end
    for (int i = 0; i < 5; i++) begin
      start_pc_v[0] = 4'd0;
      start_v[0]    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({out_valid_v[0], ready_v[0], result_v[0], carry_v[0]} !== {1'b1, 1'b0, 32'h0000_0010, 1'b1}) begin
        miscompares++;
        $display("FAIL stall_hold cycle %0d: got valid=%b ready=%b result=%h c=%b, expected valid=1 ready=0 result=00000010 c=1",
                 i, out_valid_v[0], ready_v[0], result_v[0], carry_v[0]);
      end else begin
        $display("txn stall hold cycle %0d ok", i);
      end
    end
    out_ready_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    vectors++;
    if ({ready_v[0], out_valid_v[0], result_v[0]} !== {1'b1, 1'b0, 32'h0000_0010}) begin
      miscompares++;
      $display("FAIL handshake_idle: got ready=%b valid=%b result=%h, expected ready=1 valid=0 result=00000010",
               ready_v[0], out_valid_v[0], result_v[0]);
    end else begin
      $display("txn handshake idle ok");
    end
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    vectors++;
    if ({ready_v[0], out_valid_v[0]} !== 2'b10) begin
      miscompares++;
      $display("FAIL start_ignored_in_done: got ready=%b valid=%b, expected ready=1 valid=0",
               ready_v[0], out_valid_v[0]);
    end else begin
      $display("txn start ignored in done ok");
    end
  endtask

  task automatic test_reset_mid_run();
    txn_t obs, e;
    logic saw_valid;
    start_pc_v[0] = 4'd1;
    start_v[0]    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({ready_v[0], out_valid_v[0], result_v[0], carry_v[0], neg_v[0], err_v[0]} !== {1'b1, 1'b0, 32'h0, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_mid_run: got ready=%b valid=%b result=%h c=%b n=%b e=%b, expected ready=1 valid=0 result=0 flags=0",
               ready_v[0], out_valid_v[0], result_v[0], carry_v[0], neg_v[0], err_v[0]);
    end else begin
      $display("txn reset mid run ok");
    end
    saw_valid = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      saw_valid = saw_valid | out_valid_v[0];
    end
    vectors++;
    if (saw_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL aborted_run_output: got out_valid=%b after reset, expected 0", saw_valid);
    end else begin
      $display("txn aborted run silent ok");
    end
    launch(0, 4'd0, {32'h0000_0006, 1'b0, 1'b0, 1'b0, 8'd2});
    collect(0, obs);
    e = exp_q.pop_front();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL rerun_after_reset: got result=%h c=%b lat=%0d, expected result=%h c=%b lat=%0d",
               obs.result, obs.carry, obs.lat, e.result, e.carry, e.lat);
    end else begin
      $display("txn rerun after reset result=%h lat=%0d", obs.result, obs.lat);
    end
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      start_v[u]     = 1'b0;
      start_pc_v[u]  = 4'd0;
      out_ready_v[u] = 1'b1;
    end
    test_reset();
    test_programs();
    test_backpressure();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
